riscv_wb_fwd: RTL and testbench
===============================

# riscv_wb_fwd

Writeback and forwarding unit for the 5-stage core: the write-side counterpart of the register-file control block. It accepts retiring results from the execute stage, holds them through a MEM stage while loads wait for data memory, drives the register file write port from a registered WB stage, and supplies forwarded operands plus a pipeline stall to decode.

## Interface
- `XLEN`, default 32: data width.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `i_ex_valid` input 1: EX result valid this cycle.
- `i_ex_rd` input 5: destination register.
- `i_ex_data` input XLEN: ALU result (ignored for loads).
- `i_ex_is_load` input 1: result comes from data memory.
- `i_ld_valid` input 1: load data returned this cycle.
- `i_ld_data` input XLEN: load data.
- `i_re1` / `i_re2` input 1: decode read enables.
- `i_raddr1` / `i_raddr2` input 5: decode read addresses.
- `i_rfdata1` / `i_rfdata2` input XLEN: raw register file read data.
- `o_we` output 1: register file write enable.
- `o_waddr` output 5: write address.
- `o_wdata` output XLEN: write data.
- `o_fwd1` / `o_fwd2` output XLEN: forwarded operands to decode.
- `o_stall` output 1: freeze EX and all earlier stages.

## Operation
- **MEM stage register.** Fields: `mem_valid`, `mem_rd`, `mem_data`, `mem_is_load`. Loads when `i_ex_valid && !o_stall`. Otherwise clears `mem_valid` when MEM advances, and holds while stalled.
- **FSM.**
  - States: `IDLE` and `WAIT_LD`.
  - IDLE → WAIT_LD when a load sits in MEM and `i_ld_valid` is 0.
  - WAIT_LD → IDLE on `i_ld_valid`.
- **MEM advances** when `!mem_valid || !mem_is_load || i_ld_valid`.
  - On advance the WB register captures `o_we = mem_valid && mem_rd != 0`, `o_waddr = mem_rd`, and data = `i_ld_data` if load, else `mem_data`.
  - If MEM does not advance, `o_we` drops to 0.
- **x0.** Writes to register 0 are never issued, and x0 never matches for forwarding.
- **Forwarding for each read port n.** Priority, youngest first:
  - If `i_ren` is 0 or `i_raddrn` is 0, the result is 0.
  - On a MEM match with a non-load, forward `mem_data`.
  - On a MEM match with a load and `i_ld_valid`, forward `i_ld_data`.
  - On a MEM match with a load and no `i_ld_valid`, assert the stall and forward `i_rfdata` (value don't-care).
  - On a WB match (`o_we && o_waddr == addr`), forward `o_wdata`.
  - Otherwise forward `i_rfdatan`.
- **o_stall** (combinational) = (MEM holds a load && !`i_ld_valid`) || a load-use match on either enabled port.
  - A load-use match requires `i_ld_valid` low; if it is high the data is forwarded and there is no stall.

## Timing
- **Reset** (async assert, sync release): `mem_valid` = 0, state = IDLE; `o_we` = 0, `o_waddr` = 0, `o_wdata` = 0; `o_stall` = 0; `o_fwd*` = 0.
- **Non-load latency:** EX result at edge N is in MEM; `o_we` is high during cycle N+1 and the register file writes at edge N+2.
- **Load latency:** `i_ld_valid` in cycle K gives `o_we` in cycle K+1. An unbounded wait is allowed; the stall holds throughout.
- **Simultaneous events:**
  - MEM and WB target the same rd: MEM wins.
  - `i_ld_valid` arrives in the same cycle as a dependent read: the read is forwarded and there is no stall.
  - `i_ld_valid` while MEM holds no load: ignored.
- **Back-to-back writes** to the same rd: each is written in order, and forwarding always returns the youngest.
- **Reset mid-load:** the pending load is discarded and no write occurs.

## Structure
- Shared package `riscv_pkg`:
  - `wb_state_t` enum (`IDLE`, `WAIT_LD`).
  - `REG_ZERO` = 5'd0.
  - `mem_entry_t` struct (valid, rd, data, is_load).
- Sub-module `riscv_fwd_mux`: the single-port forwarding priority mux plus its hazard flag, instantiated twice.

## Test plan
- **ALU writeback:** EX rd = 5, data = 0x1234 at edge 0 → `o_we` = 1, `o_waddr` = 5, `o_wdata` = 0x1234 in cycle 1; decode reading r5 in cycle 0 (MEM) and cycle 1 (WB) gets 0x1234.
- **x0 suppression:** EX rd = 0, data = 0xFFFF → `o_we` stays 0; a read of x0 returns 0 even with `i_rfdata` = 0xDEAD.
- **Load with 3-cycle wait:**
  - Setup: load rd = 7, with decode reading r7.
  - While waiting: `o_stall` = 1 for 3 cycles and state = WAIT_LD.
  - Return: `i_ld_data` = 0xCAFE → forwarded 0xCAFE, `o_stall` = 0, and the next cycle `o_we` writes r7 = 0xCAFE.
- **Priority:** WB holds r3 = 1 and MEM holds r3 = 2 → `o_fwd1` = 2; with `i_re1` = 0 → `o_fwd1` = 0.
- **Stall hold:** during a load stall, `i_ex_valid` with rd = 9 is held externally → it is captured exactly once after the stall releases, with no lost or duplicate write.
- **Reset mid-load:** assert `rst` in WAIT_LD → all outputs 0 immediately; a later `i_ld_valid` produces no write.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the writeback/forwarding slice of the 5-stage core.
package riscv_pkg;

    // Data width of a MEM-stage entry. Units that hold a mem_entry_t
    // must run with XLEN equal to this value.
    localparam int unsigned XLEN_DEF = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic                valid;
        logic [4:0]          rd;
        logic [XLEN_DEF-1:0] data;
        logic                is_load;
    } mem_entry_t;

endpackage

// File: rtl/riscv_fwd_mux.sv
// Single read-port forwarding mux: youngest producer wins, x0 reads as zero,
// and a MEM-stage load whose data has not returned raises a hazard.
module riscv_fwd_mux
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            i_re,
    input  logic [4:0]      i_raddr,
    input  logic [XLEN-1:0] i_rfdata,
    input  mem_entry_t      i_mem,
    input  logic            i_ld_valid,
    input  logic [XLEN-1:0] i_ld_data,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_waddr,
    input  logic [XLEN-1:0] i_wb_wdata,
    output logic [XLEN-1:0] o_fwd,
    output logic            o_hazard
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem.valid && (i_mem.rd == i_raddr);
    assign w_wb_hit  = i_wb_we && (i_wb_waddr == i_raddr);

    // Priority select: disabled/x0, then MEM, then WB, then register file.
    always_comb begin
        o_fwd    = i_rfdata;
        o_hazard = 1'b0;
        if (!i_re || (i_raddr == REG_ZERO)) begin
            o_fwd = '0;
        end else if (w_mem_hit) begin
            if (!i_mem.is_load) begin
                o_fwd = i_mem.data;
            end else if (i_ld_valid) begin
                o_fwd = i_ld_data;
            end else begin
                o_hazard = 1'b1;
            end
        end else if (w_wb_hit) begin
            o_fwd = i_wb_wdata;
        end
    end

endmodule

// File: rtl/riscv_wb_fwd.sv
// Writeback and forwarding unit: MEM holding register, registered WB stage
// driving the register file write port, and operand forwarding with stall.
module riscv_wb_fwd
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_ex_valid,
    input  logic [4:0]      i_ex_rd,
    input  logic [XLEN-1:0] i_ex_data,
    input  logic            i_ex_is_load,
    input  logic            i_ld_valid,
    input  logic [XLEN-1:0] i_ld_data,
    input  logic            i_re1,
    input  logic [4:0]      i_raddr1,
    input  logic [XLEN-1:0] i_rfdata1,
    input  logic            i_re2,
    input  logic [4:0]      i_raddr2,
    input  logic [XLEN-1:0] i_rfdata2,
    output logic            o_we,
    output logic [4:0]      o_waddr,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_fwd1,
    output logic [XLEN-1:0] o_fwd2,
    output logic            o_stall
);

    mem_entry_t      r_mem;
    wb_state_t       r_state;
    logic            w_mem_adv;
    logic            w_ld_pending;
    logic            w_haz1;
    logic            w_haz2;
    logic [XLEN-1:0] w_fwd1;
    logic [XLEN-1:0] w_fwd2;

    // A load in MEM blocks the stage until its data returns.
    assign w_mem_adv    = !r_mem.valid || !r_mem.is_load || i_ld_valid;
    assign w_ld_pending = !w_mem_adv;

    // The port hazards are subsumed by w_ld_pending; kept for clarity.
    assign o_stall = w_ld_pending || w_haz1 || w_haz2;

    // Forwarded operands read as zero while reset is held.
    assign o_fwd1 = rst ? '0 : w_fwd1;
    assign o_fwd2 = rst ? '0 : w_fwd2;

    // MEM stage: capture from EX when not stalled, drain on advance, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '0;
        end else if (i_ex_valid && !o_stall) begin
            r_mem.valid   <= 1'b1;
            r_mem.rd      <= i_ex_rd;
            r_mem.data    <= i_ex_data;
            r_mem.is_load <= i_ex_is_load;
        end else if (w_mem_adv) begin
            r_mem.valid <= 1'b0;
        end
    end

    // Load-wait tracking: enter on an outstanding load, leave on data return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_ld_pending) r_state <= WAIT_LD;
                WAIT_LD: if (i_ld_valid)   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // WB stage: register the retiring MEM entry; x0 writes are suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_we    <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
        end else if (w_mem_adv) begin
            o_we    <= r_mem.valid && (r_mem.rd != REG_ZERO);
            o_waddr <= r_mem.rd;
            o_wdata <= r_mem.is_load ? i_ld_data : r_mem.data;
        end else begin
            o_we <= 1'b0;
        end
    end

    riscv_fwd_mux #(.XLEN(XLEN)) u_fwd1 (
        .i_re       (i_re1),
        .i_raddr    (i_raddr1),
        .i_rfdata   (i_rfdata1),
        .i_mem      (r_mem),
        .i_ld_valid (i_ld_valid),
        .i_ld_data  (i_ld_data),
        .i_wb_we    (o_we),
        .i_wb_waddr (o_waddr),
        .i_wb_wdata (o_wdata),
        .o_fwd      (w_fwd1),
        .o_hazard   (w_haz1)
    );

    riscv_fwd_mux #(.XLEN(XLEN)) u_fwd2 (
        .i_re       (i_re2),
        .i_raddr    (i_raddr2),
        .i_rfdata   (i_rfdata2),
        .i_mem      (r_mem),
        .i_ld_valid (i_ld_valid),
        .i_ld_data  (i_ld_data),
        .i_wb_we    (o_we),
        .i_wb_waddr (o_waddr),
        .i_wb_wdata (o_wdata),
        .o_fwd      (w_fwd2),
        .o_hazard   (w_haz2)
    );

endmodule

// File: tb/tb_riscv_wb_fwd.sv
// Directed bench for riscv_wb_fwd: an in-flight-write model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_riscv_wb_fwd;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_ex_valid;
    logic [4:0]  i_ex_rd;
    logic [31:0] i_ex_data;
    logic        i_ex_is_load;
    logic        i_ld_valid;
    logic [31:0] i_ld_data;
    logic        i_re1;
    logic [4:0]  i_raddr1;
    logic [31:0] i_rfdata1;
    logic        i_re2;
    logic [4:0]  i_raddr2;
    logic [31:0] i_rfdata2;
    logic        o_we;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic [31:0] o_fwd1;
    logic [31:0] o_fwd2;
    logic        o_stall;

    int n_cmp = 0;
    int n_err = 0;

    riscv_wb_fwd #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_ex_valid   (i_ex_valid),
        .i_ex_rd      (i_ex_rd),
        .i_ex_data    (i_ex_data),
        .i_ex_is_load (i_ex_is_load),
        .i_ld_valid   (i_ld_valid),
        .i_ld_data    (i_ld_data),
        .i_re1        (i_re1),
        .i_raddr1     (i_raddr1),
        .i_rfdata1    (i_rfdata1),
        .i_re2        (i_re2),
        .i_raddr2     (i_raddr2),
        .i_rfdata2    (i_rfdata2),
        .o_we         (o_we),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
        .o_fwd1       (o_fwd1),
        .o_fwd2       (o_fwd2),
        .o_stall      (o_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // In-flight writes, youngest first: slot 0 = awaiting memory stage,
    // slot 1 = being written to the register file this cycle.
    typedef struct {
        bit          live;
        bit [4:0]    rd;
        bit [31:0]   data;
        bit          is_load;
    } wr_t;
    wr_t flight[2];

    function automatic bit load_blocked();
        return flight[0].live && flight[0].is_load && !i_ld_valid;
    endfunction

    // Expected operand; dc=1 when the value is don't-care (load-use stall).
    function automatic void expect_fwd(input bit re, input bit [4:0] a, input bit [31:0] rf,
                                       output bit [31:0] val, output bit dc);
        dc  = 1'b0;
        val = rf;
        if (!re || a == 5'd0) begin
            val = 32'd0;
        end else if (flight[0].live && flight[0].rd == a) begin
            if (!flight[0].is_load)  val = flight[0].data;
            else if (i_ld_valid)     val = i_ld_data;
            else                     dc = 1'b1;
        end else if (flight[1].live && flight[1].rd == a) begin
            val = flight[1].data;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            flight[0] = '{0, 0, 0, 0};
            flight[1] = '{0, 0, 0, 0};
        end else if (load_blocked()) begin
            flight[1].live = 1'b0;
        end else begin
            flight[1]      = flight[0];
            flight[1].live = flight[0].live && flight[0].rd != 5'd0;
            if (flight[0].is_load) flight[1].data = i_ld_data;
            flight[0] = '{i_ex_valid, i_ex_rd, i_ex_data, i_ex_is_load};
        end
    end

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        bit [31:0] v;
        bit        dc;
        if (rst) begin
            check("m_rst_we",   {31'd0, o_we},    32'd0);
            check("m_rst_wa",   {27'd0, o_waddr}, 32'd0);
            check("m_rst_wd",   o_wdata,          32'd0);
            check("m_rst_st",   {31'd0, o_stall}, 32'd0);
            check("m_rst_f1",   o_fwd1,           32'd0);
            check("m_rst_f2",   o_fwd2,           32'd0);
        end else begin
            check("m_we", {31'd0, o_we}, {31'd0, flight[1].live});
            if (flight[1].live) begin
                check("m_waddr", {27'd0, o_waddr}, {27'd0, flight[1].rd});
                check("m_wdata", o_wdata, flight[1].data);
            end
            check("m_stall", {31'd0, o_stall}, {31'd0, load_blocked()});
            expect_fwd(i_re1, i_raddr1, i_rfdata1, v, dc);
            if (!dc) check("m_fwd1", o_fwd1, v);
            expect_fwd(i_re2, i_raddr2, i_rfdata2, v, dc);
            if (!dc) check("m_fwd2", o_fwd2, v);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        i_ex_valid = 0; i_ex_rd = 0; i_ex_data = 0; i_ex_is_load = 0;
        i_ld_valid = 0; i_ld_data = 0;
        i_re1 = 0; i_raddr1 = 0; i_rfdata1 = 0;
        i_re2 = 0; i_raddr2 = 0; i_rfdata2 = 0;
    endtask

    task automatic ex(input logic [4:0] rd, input logic [31:0] d, input logic ld);
        i_ex_valid = 1; i_ex_rd = rd; i_ex_data = d; i_ex_is_load = ld;
    endtask

    task automatic rd1(input logic [4:0] a, input logic [31:0] rf);
        i_re1 = 1; i_raddr1 = a; i_rfdata1 = rf;
    endtask

    task automatic rd2(input logic [4:0] a, input logic [31:0] rf);
        i_re2 = 1; i_raddr2 = a; i_rfdata2 = rf;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic at_pos();
        @(posedge clk); #1;
    endtask

    task automatic chk_wb(input string n, input logic we, input logic [4:0] a, input logic [31:0] d);
        check({n, "_we"}, {31'd0, o_we}, {31'd0, we});
        if (we) begin
            check({n, "_waddr"}, {27'd0, o_waddr}, {27'd0, a});
            check({n, "_wdata"}, o_wdata, d);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        // Reset: outputs zero even with an enabled read of a nonzero register.
        rd1(5'd5, 32'hAAAA);
        at_neg();
        check("rst_fwd1",  o_fwd1, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        chk_wb("rst", 1'b0, 5'd0, 32'd0);
        at_pos(); at_pos();
        rst = 1'b0;
        idle();
        at_pos();

        // ALU writeback and forwarding from MEM then WB.
        ex(5'd5, 32'h1234, 1'b0);
        at_pos();
        idle(); rd1(5'd5, 32'h5555); rd2(5'd5, 32'h6666);
        at_neg();
        check("alu_mem_fwd1", o_fwd1, 32'h1234);
        check("alu_mem_fwd2", o_fwd2, 32'h1234);
        chk_wb("alu_c0", 1'b0, 5'd0, 32'd0);
        at_pos();
        at_neg();
        chk_wb("alu_c1", 1'b1, 5'd5, 32'h1234);
        check("alu_wb_fwd1", o_fwd1, 32'h1234);
        at_pos();
        at_neg();
        chk_wb("alu_c2", 1'b0, 5'd0, 32'd0);
        check("alu_rf_fwd1", o_fwd1, 32'h5555);
        at_pos();

        // x0 suppression.
        idle(); ex(5'd0, 32'hFFFF, 1'b0);
        at_pos();
        idle(); rd1(5'd0, 32'hDEAD);
        at_neg();
        check("x0_fwd_mem", o_fwd1, 32'd0);
        at_pos();
        at_neg();
        check("x0_we", {31'd0, o_we}, 32'd0);
        check("x0_fwd_wb", o_fwd1, 32'd0);
        at_pos();

        // Load to r7 with a 3-cycle wait, decode reading r7 on both ports.
        idle(); ex(5'd7, 32'h0BAD, 1'b1);
        at_pos();
        idle(); rd1(5'd7, 32'h1111); rd2(5'd7, 32'h2222);
        for (int unsigned k = 0; k < 3; k++) begin
            at_neg();
            check("ld_wait_stall", {31'd0, o_stall}, 32'd1);
            if (k > 0) check("ld_wait_state", {31'd0, dut.r_state == WAIT_LD}, 32'd1);
            at_pos();
        end
        i_ld_valid = 1; i_ld_data = 32'hCAFE;
        at_neg();
        check("ld_ret_fwd1",  o_fwd1, 32'hCAFE);
        check("ld_ret_fwd2",  o_fwd2, 32'hCAFE);
        check("ld_ret_stall", {31'd0, o_stall}, 32'd0);
        at_pos();
        i_ld_valid = 0; i_ld_data = 0;
        at_neg();
        chk_wb("ld_wb", 1'b1, 5'd7, 32'hCAFE);
        check("ld_wb_fwd1", o_fwd1, 32'hCAFE);
        at_pos();

        // Priority: MEM r3=2 beats WB r3=1; disabled read returns 0.
        idle(); ex(5'd3, 32'd1, 1'b0);
        at_pos();
        ex(5'd3, 32'd2, 1'b0);
        at_pos();
        idle(); rd1(5'd3, 32'h3333);
        at_neg();
        chk_wb("prio", 1'b1, 5'd3, 32'd1);
        check("prio_fwd1", o_fwd1, 32'd2);
        i_re1 = 0; #1;
        check("prio_re0_fwd1", o_fwd1, 32'd0);
        at_pos();

        // Stall hold: EX r9 held during load r8 stall, captured once.
        idle(); ex(5'd8, 32'h0, 1'b1);
        at_pos();
        ex(5'd9, 32'h99, 1'b0);
        for (int unsigned k = 0; k < 2; k++) begin
            at_neg();
            check("hold_stall", {31'd0, o_stall}, 32'd1);
            at_pos();
        end
        i_ld_valid = 1; i_ld_data = 32'h88;
        at_neg();
        check("hold_release", {31'd0, o_stall}, 32'd0);
        at_pos();
        idle();
        at_neg();
        chk_wb("hold_w8", 1'b1, 5'd8, 32'h88);
        at_pos();
        at_neg();
        chk_wb("hold_w9", 1'b1, 5'd9, 32'h99);
        at_pos();
        at_neg();
        chk_wb("hold_done", 1'b0, 5'd0, 32'd0);
        at_pos();

        // Back-to-back writes to r4: each written in order, youngest forwarded.
        idle(); ex(5'd4, 32'hA1, 1'b0);
        at_pos();
        ex(5'd4, 32'hA2, 1'b0); rd1(5'd4, 32'h0);
        at_neg();
        check("b2b_fwd_a1", o_fwd1, 32'hA1);
        at_pos();
        idle(); rd1(5'd4, 32'h0);
        at_neg();
        chk_wb("b2b_w1", 1'b1, 5'd4, 32'hA1);
        check("b2b_fwd_a2", o_fwd1, 32'hA2);
        at_pos();
        at_neg();
        chk_wb("b2b_w2", 1'b1, 5'd4, 32'hA2);
        at_pos();

        // Reset during a load wait: everything clears, late data ignored.
        idle(); ex(5'd10, 32'h0, 1'b1);
        at_pos();
        idle(); rd1(5'd10, 32'h4444);
        at_neg();
        check("rml_stall", {31'd0, o_stall}, 32'd1);
        at_pos();
        at_neg();
        check("rml_state", {31'd0, dut.r_state == WAIT_LD}, 32'd1);
        rst = 1'b1; #1;
        check("rml_we",    {31'd0, o_we},    32'd0);
        check("rml_waddr", {27'd0, o_waddr}, 32'd0);
        check("rml_wdata", o_wdata,          32'd0);
        check("rml_stall0",{31'd0, o_stall}, 32'd0);
        check("rml_fwd1",  o_fwd1,           32'd0);
        at_pos();
        rst = 1'b0;
        i_ld_valid = 1; i_ld_data = 32'hBAD;
        at_neg();
        check("rml_late_stall", {31'd0, o_stall}, 32'd0);
        check("rml_late_fwd1",  o_fwd1, 32'h4444);
        at_pos();
        idle();
        at_neg();
        check("rml_no_write", {31'd0, o_we}, 32'd0);
        at_pos();
        at_pos();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
